adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
// PURPOSE
//  Shares one 16-bit add/subtract datapath between two requesters (port 0, port 1), using
//  the adder op-code set.
//  Round-robin arbitration; one operation in flight; per-port carry flag for ADC/SBB chaining.
//  Sits between the instruction sequencers and the arithmetic unit of the 16-bit RISC ALU.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; all widths below are WIDTH unless stated
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous, active-high reset
//  req0     in   1      port 0 request; held high with op/operands stable until done0
//  op0      in   3      port 0 op: 000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 INC, 101 DEC
//  a0, b0   in   16     port 0 operands (b0 ignored for INC/DEC)
//  ce0      in   1      port 0 carry-enable: 1 = write cout into port 0 carry flag
//  req1, op1, a1, b1, ce1   same for port 1
//  done0    out  1      one-cycle pulse: port 0 result valid
//  done1    out  1      one-cycle pulse: port 1 result valid
//  result   out  16     registered result of last completed op
//  vout     out  1      signed overflow of last op
//  cout     out  1      carry (add/INC) or borrow (SUB/SBB/DEC) of last op
//  err      out  1      last op had an illegal code (110/111)
//  busy     out  1      high in EXEC and DONE
// BEHAVIOUR
//  - Reset: state IDLE; done0/done1/result/vout/cout/err/busy = 0.
//    Carry flags cf0 = cf1 = 0. last_grant = 1, so port 0 wins first.
//  - FSM IDLE -> EXEC -> DONE -> IDLE; one op per 3 cycles.
//  - IDLE, any req high: grant the port. If both are high, grant the port != last_grant.
//    Latch op/a/b/ce of the granted port and set last_grant. Go to EXEC.
//    No req: stay in IDLE.
//  - EXEC: compute with a 17-bit sum; register result, vout, cout, err; go to DONE.
//    If ce of the granted port = 1 and op is legal, write cout into that port's cf.
//  - DONE: done of the granted port = 1 for exactly this cycle; go to IDLE.
//  - Latency: req sampled in cycle N -> done in cycle N+2. result and flags hold until the
//    next EXEC.
//  - Requester must drop req the cycle after done. A req still high in IDLE is a new request.
//  - Arithmetic, modulo 2^16:
//    - ADD A+B
//    - ADC A+B+cf
//    - SUB A-B
//    - SBB A-B-cf
//    - INC A+1
//    - DEC A-1
//  - cout for add ops is bit 16 of the 17-bit sum.
//  - cout for sub ops is the borrow: 1 iff unsigned A < (B + cf) (B = 1 for DEC).
//  - vout = signed overflow: operands of equal sign (effective sign for sub) give a result
//    of opposite sign.
//  - Illegal op 110/111: result = 0, vout = cout = 0, err = 1, cf unchanged, done still
//    pulses.
//  - Operand changes on the ungranted port have no effect. Changes on the granted port
//    after the IDLE latch are ignored.
//  - rst in any state aborts the op: no done pulse, all outputs and cf cleared the
//    following cycle.
// TESTING
//  - ADD to overflow: port0 ADD 7F00+0300 -> result 8200, vout 1, cout 0; done0 2 cycles
//    after req.
//  - ADC chain: port0 ce0=1 ADD FF00+0100 -> 0000, cout 1, cf0 = 1.
//    Then ADC 000F+000F -> 001F, cout 0, cf0 = 0.
//  - Simultaneous requests after reset:
//    - port0 SUB 0000-0001 -> FFFF, cout 1, vout 0, done0 at N+2.
//    - port1 ADD 0000+0001 -> 0001, done1 at N+5.
//    - Next contention grants port0 again.
//  - INC/DEC edges: INC 7FFF -> 8000, vout 1; INC FFFF -> 0000, cout 1;
//    DEC 0000 -> FFFF, cout 1; DEC 8000 -> 7FFF, vout 1.
//  - Illegal op: port1 op 110 ce1=1 with cf1=1 -> result 0000, err 1, cf1 stays 1, done1
//    pulses.
//  - Reset mid-op: rst in EXEC -> no done pulse; next cycle result 0, busy 0, cf0 = cf1 = 0,
//    state IDLE.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one WIDTH-bit add/subtract datapath.
// Arbitration is round-robin, and only one operation is in flight at a time.
// Each port keeps its own carry flag so it can chain ADC/SBB operations.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   req0/op0/a0/b0/ce0         port 0 request, op-code, operands, carry-enable
//   req1/op1/a1/b1/ce1         port 1 request, op-code, operands, carry-enable
//   done0, done1               one-cycle completion pulse for each port
//   result, vout, cout, err    registered result and flags of the last op
//   busy                       high while an op is in EXEC or DONE
module adder_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             ce0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             ce1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             vout,
  output logic             cout,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic             last_grant;
  logic             gnt, gnt_q;
  logic             latch_en, exec_en;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             ce_q;
  logic             cf0, cf1;

  logic             sub_op, legal, cin, ovf;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1) state_nx = EXEC;
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM control: grant choice and the enables for the latch and execute steps
  always_comb begin
    latch_en = 1'b0;
    exec_en  = 1'b0;
    // When both ports request, the port that did not win last time gets the grant
    gnt      = (req0 && req1) ? ~last_grant : req1;
    case (state)
      IDLE:    latch_en = req0 || req1;
      EXEC:    exec_en  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: a 17-bit sum or difference, so bit WIDTH gives the carry or the borrow
  always_comb begin
    sub_op = 1'b0;
    b_eff  = b_q;
    cin    = 1'b0;
    legal  = (op_q[2:1] != 2'b11);
    case (op_q)
      3'b001:  cin = gnt_q ? cf1 : cf0;
      3'b010:  sub_op = 1'b1;
      3'b011:  begin sub_op = 1'b1; cin = gnt_q ? cf1 : cf0; end
      3'b100:  b_eff = WIDTH'(1);
      3'b101:  begin sub_op = 1'b1; b_eff = WIDTH'(1); end
      default: ;
    endcase
    if (sub_op) begin
      sum = {1'b0, a_q} - {1'b0, b_eff} - {{WIDTH{1'b0}}, cin};
      ovf = (a_q[WIDTH-1] ^ b_eff[WIDTH-1]) & (a_q[WIDTH-1] ^ sum[WIDTH-1]);
    end else begin
      sum = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      ovf = ~(a_q[WIDTH-1] ^ b_eff[WIDTH-1]) & (a_q[WIDTH-1] ^ sum[WIDTH-1]);
    end
    if (!legal) begin
      sum = '0;
      ovf = 1'b0;
    end
  end

  // Registered request latch, results, flags and carry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ce_q       <= 1'b0;
      cf0        <= 1'b0;
      cf1        <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result     <= '0;
      vout       <= 1'b0;
      cout       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= (state_nx != IDLE);
      if (latch_en) begin
        gnt_q      <= gnt;
        last_grant <= gnt;
        op_q       <= gnt ? op1 : op0;
        a_q        <= gnt ? a1 : a0;
        b_q        <= gnt ? b1 : b0;
        ce_q       <= gnt ? ce1 : ce0;
      end
      if (exec_en) begin
        result <= sum[WIDTH-1:0];
        vout   <= ovf;
        cout   <= sum[WIDTH];
        err    <= ~legal;
        // The done pulse is registered here, so it appears during the DONE state
        done0  <= ~gnt_q;
        done1  <= gnt_q;
        if (ce_q && legal) begin
          if (gnt_q) cf1 <= sum[WIDTH];
          else       cf0 <= sum[WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, ce0, ce1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        done0, done1, vout, cout, err, busy;
  logic [15:0] result;

  int tests = 0;
  int fails = 0;

  adder_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ce0(ce0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ce1(ce1),
    .done0(done0), .done1(done1), .result(result),
    .vout(vout), .cout(cout), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input bit p, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic ce);
    if (p) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; ce1 = ce; end
    else   begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; ce0 = ce; end
  endtask

  // Single-port op. After the latch, the granted port's operands are scrambled
  // and the idle port's operands are changed; the result must not move.
  task automatic run_op(input string tag, input bit p, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic ce,
                        input logic [15:0] er, input logic ev, input logic ec,
                        input logic ee);
    set_port(p, op, a, b, ce);
    tick();
    chk({tag, " busy_exec"}, 32'(busy), 32'd1);
    if (p) begin a1 = a1 ^ 16'hA5A5; b1 = ~b1; op1 = 3'b000; a0 = 16'h1357; end
    else   begin a0 = a0 ^ 16'hA5A5; b0 = ~b0; op0 = 3'b000; a1 = 16'h1357; end
    tick();
    chk({tag, " done"}, {30'd0, done1, done0}, p ? 32'd2 : 32'd1);
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " flags"}, {29'd0, vout, cout, err}, {29'd0, ev, ec, ee});
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk({tag, " idle"}, {29'd0, busy, done1, done0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; ce0 = 1'b0; ce1 = 1'b0;
    op0 = 3'b000; op1 = 3'b000; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick();
    tick();
    chk("reset outputs", {25'd0, done0, done1, vout, cout, err, busy, 1'b0},  32'd0);
    chk("reset result", 32'(result), 32'd0);
    rst = 1'b0;
    tick();

    // Simultaneous requests after reset: port 0 first, then port 1
    set_port(1'b0, 3'b010, 16'h0000, 16'h0001, 1'b0);
    set_port(1'b1, 3'b000, 16'h0000, 16'h0001, 1'b0);
    tick();
    chk("sim N+1 done", {30'd0, done1, done0}, 32'd0);
    tick();
    chk("sim N+2 done0", {30'd0, done1, done0}, 32'd1);
    chk("sim sub result", 32'(result), 32'h0000FFFF);
    chk("sim sub flags", {30'd0, vout, cout}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("sim N+3 idle", {29'd0, busy, done1, done0}, 32'd0);
    tick();
    chk("sim N+4 busy", {29'd0, busy, done1, done0}, 32'd4);
    tick();
    chk("sim N+5 done1", {30'd0, done1, done0}, 32'd2);
    chk("sim add result", 32'(result), 32'h00000001);

    // Next contention: port 1 was served last, so port 0 wins
    set_port(1'b0, 3'b000, 16'h0001, 16'h0001, 1'b0);
    set_port(1'b1, 3'b000, 16'h0005, 16'h0005, 1'b0);
    tick();
    tick();
    tick();
    chk("rr done0", {30'd0, done1, done0}, 32'd1);
    chk("rr result0", 32'(result), 32'h00000002);
    req0 = 1'b0;
    tick();
    tick();
    tick();
    chk("rr done1", {30'd0, done1, done0}, 32'd2);
    chk("rr result1", 32'(result), 32'h0000000A);
    req1 = 1'b0;
    tick();

    run_op("add ovf", 1'b0, 3'b000, 16'h7F00, 16'h0300, 1'b0, 16'h8200, 1'b1, 1'b0, 1'b0);
    run_op("adc set", 1'b0, 3'b000, 16'hFF00, 16'h0100, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("cf0 set", 32'(dut.cf0), 32'd1);
    run_op("adc use", 1'b0, 3'b001, 16'h000F, 16'h000F, 1'b1, 16'h001F, 1'b0, 1'b0, 1'b0);
    chk("cf0 clr", 32'(dut.cf0), 32'd0);

    run_op("inc 7fff", 1'b1, 3'b100, 16'h7FFF, 16'h1234, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0);
    run_op("inc ffff", 1'b1, 3'b100, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("dec 0000", 1'b0, 3'b101, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    run_op("dec 8000", 1'b0, 3'b101, 16'h8000, 16'h1234, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0);

    // Illegal op must leave cf1 = 1; a following SBB consumes it
    run_op("cf1 set", 1'b1, 3'b000, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("illegal", 1'b1, 3'b110, 16'h1234, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("cf1 kept", 32'(dut.cf1), 32'd1);
    run_op("sbb", 1'b1, 3'b011, 16'h0005, 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    run_op("sub sgn", 1'b0, 3'b010, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0);

    // Reset during EXEC aborts the op with no done pulse
    run_op("pre rst", 1'b1, 3'b000, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);
    set_port(1'b0, 3'b000, 16'h0001, 16'h0002, 1'b1);
    tick();
    chk("rst in exec", 32'(busy), 32'd1);
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    chk("rst done", {30'd0, done1, done0}, 32'd0);
    chk("rst outs", {28'd0, vout, cout, err, busy}, 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst cf", {30'd0, dut.cf1, dut.cf0}, 32'd0);
    chk("rst state", 32'(dut.state), 32'd0);
    rst = 1'b0;
    tick();
    chk("post rst quiet", {30'd0, done1, done0}, 32'd0);

    // last_grant was reset, so port 0 wins again
    set_port(1'b0, 3'b000, 16'h0010, 16'h0020, 1'b0);
    set_port(1'b1, 3'b010, 16'h0010, 16'h0020, 1'b0);
    tick();
    tick();
    chk("post rst done0", {30'd0, done1, done0}, 32'd1);
    chk("post rst res0", 32'(result), 32'h00000030);
    req0 = 1'b0;
    tick();
    tick();
    tick();
    chk("post rst done1", {30'd0, done1, done0}, 32'd2);
    chk("post rst res1", 32'(result), 32'h0000FFF0);
    chk("post rst flags1", {30'd0, vout, cout}, 32'd1);
    req1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
